// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the MIPS core: load-use hazard detection,
// bubble insertion on stall/flush, and EX-stage operand forwarding into the ALU.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [2:0]        id_op,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [DATA_W-1:0] id_rs_val,
    input  logic [DATA_W-1:0] id_rt_val,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_use_imm,
    input  logic              id_is_load,
    input  logic              id_reg_write,
    input  logic              flush,
    input  logic              exmem_reg_write,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [DATA_W-1:0] exmem_alu_out,
    input  logic              memwb_reg_write,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] memwb_data,
    output logic              stall,
    output logic              ex_valid,
    output logic [2:0]        alu_op,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_reg_write,
    output logic              ex_is_load,
    output logic [15:0]       stall_cnt
);

    localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};

    logic              valid_r;
    logic [2:0]        op_r;
    logic [REG_AW-1:0] rs_r;
    logic [REG_AW-1:0] rt_r;
    logic [REG_AW-1:0] rd_r;
    logic [DATA_W-1:0] rs_val_r;
    logic [DATA_W-1:0] rt_val_r;
    logic [DATA_W-1:0] imm_r;
    logic              use_imm_r;
    logic              is_load_r;
    logic              reg_write_r;
    logic [15:0]       stall_cnt_r;
    logic              stall_s;
    logic              bubble_s;
    logic [DATA_W-1:0] fwd_rs_s;
    logic [DATA_W-1:0] fwd_rt_s;

    // Load-use hazard detection; a flush kills the consumer so it never stalls.
    always_comb begin
        stall_s = 1'b0;
        if (!flush && id_valid && valid_r && is_load_r && (rd_r != REG_ZERO) &&
            ((id_rs == rd_r) || (!id_use_imm && (id_rt == rd_r)))) begin
            stall_s = 1'b1;
        end else begin
            stall_s = 1'b0;
        end
    end

    assign bubble_s = flush | stall_s | ~id_valid;

    // Stage register: bubble (all fields cleared) or capture of the decoded instruction.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_r     <= 1'b0;
            op_r        <= 3'd0;
            rs_r        <= REG_ZERO;
            rt_r        <= REG_ZERO;
            rd_r        <= REG_ZERO;
            rs_val_r    <= {DATA_W{1'b0}};
            rt_val_r    <= {DATA_W{1'b0}};
            imm_r       <= {DATA_W{1'b0}};
            use_imm_r   <= 1'b0;
            is_load_r   <= 1'b0;
            reg_write_r <= 1'b0;
        end else if (bubble_s) begin
            valid_r     <= 1'b0;
            op_r        <= 3'd0;
            rs_r        <= REG_ZERO;
            rt_r        <= REG_ZERO;
            rd_r        <= REG_ZERO;
            rs_val_r    <= {DATA_W{1'b0}};
            rt_val_r    <= {DATA_W{1'b0}};
            imm_r       <= {DATA_W{1'b0}};
            use_imm_r   <= 1'b0;
            is_load_r   <= 1'b0;
            reg_write_r <= 1'b0;
        end else begin
            valid_r     <= id_valid;
            op_r        <= id_op;
            rs_r        <= id_rs;
            rt_r        <= id_rt;
            rd_r        <= id_rd;
            rs_val_r    <= id_rs_val;
            rt_val_r    <= id_rt_val;
            imm_r       <= id_imm;
            use_imm_r   <= id_use_imm;
            is_load_r   <= id_is_load;
            reg_write_r <= id_reg_write;
        end
    end

    // Saturating count of load-use stall cycles.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt_r <= 16'd0;
        end else if (stall_s && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    // Operand forwarding; the younger EX/MEM result beats MEM/WB, and r0 never forwards.
    always_comb begin
        fwd_rs_s = rs_val_r;
        fwd_rt_s = rt_val_r;
        if (exmem_reg_write && (exmem_rd != REG_ZERO) && (exmem_rd == rs_r)) begin
            fwd_rs_s = exmem_alu_out;
        end else if (memwb_reg_write && (memwb_rd != REG_ZERO) && (memwb_rd == rs_r)) begin
            fwd_rs_s = memwb_data;
        end else begin
            fwd_rs_s = rs_val_r;
        end
        if (exmem_reg_write && (exmem_rd != REG_ZERO) && (exmem_rd == rt_r)) begin
            fwd_rt_s = exmem_alu_out;
        end else if (memwb_reg_write && (memwb_rd != REG_ZERO) && (memwb_rd == rt_r)) begin
            fwd_rt_s = memwb_data;
        end else begin
            fwd_rt_s = rt_val_r;
        end
    end

    assign stall        = stall_s;
    assign ex_valid     = valid_r;
    assign alu_op       = op_r;
    assign alu_in1      = fwd_rs_s;
    assign alu_in2      = use_imm_r ? imm_r : fwd_rt_s;
    assign ex_rd        = rd_r;
    assign ex_reg_write = reg_write_r;
    assign ex_is_load   = is_load_r;
    assign stall_cnt    = stall_cnt_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage: stimulus pushes hand-computed expectations
// into a queue, and a separate monitor pops and compares when a sample is presented.
module tb_id_ex_stage;

    logic        clock;
    logic        reset;
    logic        id_valid;
    logic [2:0]  id_op;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rs_val, id_rt_val, id_imm;
    logic        id_use_imm, id_is_load, id_reg_write, flush;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_alu_out, memwb_data;
    logic        stall, ex_valid, ex_reg_write, ex_is_load;
    logic [2:0]  alu_op;
    logic [31:0] alu_in1, alu_in2;
    logic [4:0]  ex_rd;
    logic [15:0] stall_cnt;

    typedef struct {
        string       name;
        logic        v;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        st;
        logic [15:0] cnt;
        logic [4:0]  rd;
        logic        rw;
        logic        ld;
    } exp_t;

    exp_t sbq[$];
    event sample_ev;
    int   nvec = 0;
    int   nerr = 0;

    id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_op(id_op),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_imm(id_imm),
        .id_use_imm(id_use_imm), .id_is_load(id_is_load), .id_reg_write(id_reg_write),
        .flush(flush),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_alu_out(exmem_alu_out),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
        .stall(stall), .ex_valid(ex_valid), .alu_op(alu_op),
        .alu_in1(alu_in1), .alu_in2(alu_in2),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
        .stall_cnt(stall_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic cmp(input string n, input string f, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", n, f, act, exp);
        end
    endtask

    // Monitor: consumes one expectation per presented sample.
    always @(sample_ev) begin
        exp_t e;
        if (sbq.size() == 0) begin
            cmp("monitor", "queue_nonempty", 32'd0, 32'd1);
        end else begin
            e = sbq.pop_front();
            cmp(e.name, "stall",        {31'd0, stall},        {31'd0, e.st});
            cmp(e.name, "ex_valid",     {31'd0, ex_valid},     {31'd0, e.v});
            cmp(e.name, "alu_op",       {29'd0, alu_op},       {29'd0, e.op});
            cmp(e.name, "alu_in1",      alu_in1,               e.a);
            cmp(e.name, "alu_in2",      alu_in2,               e.b);
            cmp(e.name, "ex_rd",        {27'd0, ex_rd},        {27'd0, e.rd});
            cmp(e.name, "ex_reg_write", {31'd0, ex_reg_write}, {31'd0, e.rw});
            cmp(e.name, "ex_is_load",   {31'd0, ex_is_load},   {31'd0, e.ld});
            cmp(e.name, "stall_cnt",    {16'd0, stall_cnt},    {16'd0, e.cnt});
        end
    end

    task automatic chk(input string n, input logic v, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic st,
                       input logic [15:0] cnt, input logic [4:0] rd, input logic rw, input logic ld);
        exp_t e;
        #1;
        e.name = n; e.v = v; e.op = op; e.a = a; e.b = b;
        e.st = st; e.cnt = cnt; e.rd = rd; e.rw = rw; e.ld = ld;
        sbq.push_back(e);
        -> sample_ev;
        #1;
    endtask

    task automatic issue(input logic v, input logic [2:0] op, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] rsv,
                         input logic [31:0] rtv, input logic [31:0] imm, input logic ui,
                         input logic ld, input logic rw);
        id_valid = v; id_op = op; id_rs = rs; id_rt = rt; id_rd = rd;
        id_rs_val = rsv; id_rt_val = rtv; id_imm = imm;
        id_use_imm = ui; id_is_load = ld; id_reg_write = rw;
    endtask

    task automatic set_fwd(input logic ew, input logic [4:0] erd, input logic [31:0] eval,
                           input logic mw, input logic [4:0] mrd, input logic [31:0] mval);
        exmem_reg_write = ew; exmem_rd = erd; exmem_alu_out = eval;
        memwb_reg_write = mw; memwb_rd = mrd; memwb_data = mval;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        issue(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk("reset", 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 16'd0, 5'd0, 1'b0, 1'b0);
        @(negedge clock);
        reset = 1'b0;

        // Plain pass-through
        issue(1'b1, 3'd1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 1'b0, 1'b0, 1'b1);
        tick();
        chk("pass", 1'b1, 3'd1, 32'd5, 32'd7, 1'b0, 16'd0, 5'd3, 1'b1, 1'b0);

        // Forwarding: EX holds rs=3, rt=4
        issue(1'b1, 3'd2, 5'd3, 5'd4, 5'd5, 32'h11, 32'h22, 32'h99, 1'b0, 1'b0, 1'b1);
        tick();
        issue(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        set_fwd(1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd3, 32'h5555);
        chk("fwd_exmem_pri", 1'b1, 3'd2, 32'hAAAA, 32'h22, 1'b0, 16'd0, 5'd5, 1'b1, 1'b0);
        set_fwd(1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd4, 32'h5555);
        chk("fwd_dual", 1'b1, 3'd2, 32'hAAAA, 32'h5555, 1'b0, 16'd0, 5'd5, 1'b1, 1'b0);
        set_fwd(1'b1, 5'd0, 32'hAAAA, 1'b1, 5'd0, 32'h5555);
        chk("fwd_r0", 1'b1, 3'd2, 32'h11, 32'h22, 1'b0, 16'd0, 5'd5, 1'b1, 1'b0);
        set_fwd(1'b0, 5'd3, 32'hAAAA, 1'b1, 5'd3, 32'h5555);
        chk("fwd_memwb", 1'b1, 3'd2, 32'h5555, 32'h22, 1'b0, 16'd0, 5'd5, 1'b1, 1'b0);
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // id_valid=0 loads a bubble
        issue(1'b0, 3'd5, 5'd1, 5'd1, 5'd7, 32'd1, 32'd1, 32'd1, 1'b0, 1'b1, 1'b1);
        tick();
        chk("invalid_bubble", 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 16'd0, 5'd0, 1'b0, 1'b0);

        // Load to r0 never stalls
        issue(1'b1, 3'd0, 5'd0, 5'd0, 5'd0, 32'h1, 32'd0, 32'h4, 1'b1, 1'b1, 1'b1);
        tick();
        issue(1'b1, 3'd1, 5'd0, 5'd0, 5'd6, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        chk("r0_no_stall", 1'b1, 3'd0, 32'h1, 32'h4, 1'b0, 16'd0, 5'd0, 1'b1, 1'b1);

        // Load-use: one stall, a bubble, then MEM/WB forwarding
        issue(1'b1, 3'd0, 5'd1, 5'd0, 5'd8, 32'h100, 32'd0, 32'h8, 1'b1, 1'b1, 1'b1);
        tick();
        issue(1'b1, 3'd3, 5'd8, 5'd2, 5'd9, 32'hDEAD, 32'h20, 32'd0, 1'b0, 1'b0, 1'b1);
        chk("lu_stall", 1'b1, 3'd0, 32'h100, 32'h8, 1'b1, 16'd0, 5'd8, 1'b1, 1'b1);
        tick();
        chk("lu_bubble", 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 16'd1, 5'd0, 1'b0, 1'b0);
        set_fwd(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'h1234);
        tick();
        chk("lu_fwd", 1'b1, 3'd3, 32'h1234, 32'h20, 1'b0, 16'd1, 5'd9, 1'b1, 1'b0);
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // Immediate masks an rt hazard
        issue(1'b1, 3'd0, 5'd1, 5'd0, 5'd8, 32'h100, 32'd0, 32'h8, 1'b1, 1'b1, 1'b1);
        tick();
        issue(1'b1, 3'd4, 5'd2, 5'd8, 5'd10, 32'h30, 32'h40, 32'h77, 1'b1, 1'b0, 1'b1);
        chk("imm_no_stall", 1'b1, 3'd0, 32'h100, 32'h8, 1'b0, 16'd1, 5'd8, 1'b1, 1'b1);
        tick();
        chk("imm_mask", 1'b1, 3'd4, 32'h30, 32'h77, 1'b0, 16'd1, 5'd10, 1'b1, 1'b0);

        // Flush beats a simultaneous load-use
        issue(1'b1, 3'd0, 5'd1, 5'd0, 5'd8, 32'h100, 32'd0, 32'h8, 1'b1, 1'b1, 1'b1);
        tick();
        issue(1'b1, 3'd3, 5'd8, 5'd2, 5'd9, 32'hDEAD, 32'h20, 32'd0, 1'b0, 1'b0, 1'b1);
        flush = 1'b1;
        chk("flush_no_stall", 1'b1, 3'd0, 32'h100, 32'h8, 1'b0, 16'd1, 5'd8, 1'b1, 1'b1);
        tick();
        chk("flush_bubble", 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 16'd1, 5'd0, 1'b0, 1'b0);
        flush = 1'b0;

        // Asynchronous reset mid-cycle, held across an edge
        issue(1'b1, 3'd2, 5'd1, 5'd2, 5'd6, 32'h55, 32'h66, 32'd0, 1'b0, 1'b1, 1'b1);
        tick();
        chk("pre_reset", 1'b1, 3'd2, 32'h55, 32'h66, 1'b0, 16'd1, 5'd6, 1'b1, 1'b1);
        #1;
        reset = 1'b1;
        chk("async_reset", 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 16'd0, 5'd0, 1'b0, 1'b0);
        tick();
        chk("reset_held", 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 16'd0, 5'd0, 1'b0, 1'b0);
        issue(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        reset = 1'b0;

        // Saturation: preset the counter near the top, then three rt-path load-use stalls
        @(negedge clock);
        force dut.stall_cnt_r = 16'hFFFE;
        #1;
        release dut.stall_cnt_r;
        chk("sat_preset", 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 16'hFFFE, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            issue(1'b1, 3'd0, 5'd1, 5'd0, 5'd12, 32'h1, 32'd0, 32'h2, 1'b1, 1'b1, 1'b1);
            tick();
            issue(1'b1, 3'd1, 5'd3, 5'd12, 5'd13, 32'h7, 32'h9, 32'd0, 1'b0, 1'b0, 1'b1);
            chk("sat_stall", 1'b1, 3'd0, 32'h1, 32'h2, 1'b1, (i == 0) ? 16'hFFFE : 16'hFFFF,
                5'd12, 1'b1, 1'b1);
            tick();
            chk("sat_cnt", 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 16'hFFFF, 5'd0, 1'b0, 1'b0);
        end

        #5;
        cmp("scoreboard", "leftover", sbq.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the MIPS core. It sits directly upstream of the ALU and registers the decoded instruction on each clock. It then drives the ALU's `op`, `in1` and `in2` through an EX-stage forwarding mux fed from EX/MEM and MEM/WB. It also detects load-use hazards, inserts bubbles, and honours branch flushes.

## Interface
Parameters:
- DATA_W, 32, datapath width
- REG_AW, 5, register address width

Ports:
- clock  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high; clears all stage state
- id_valid  in  1  decode stage holds a real instruction
- id_op  in  3  ALU opcode (0..5, ALU encoding)
- id_rs, id_rt  in  REG_AW  source register numbers
- id_rd  in  REG_AW  destination register number
- id_rs_val, id_rt_val  in  DATA_W  register-file read data
- id_imm  in  DATA_W  sign-extended immediate
- id_use_imm  in  1  in2 takes the immediate instead of rt
- id_is_load  in  1  instruction is a load
- id_reg_write  in  1  instruction writes rd
- flush  in  1  branch taken; kill the instruction in ID
- exmem_reg_write, exmem_rd, exmem_alu_out  in  1/REG_AW/DATA_W  EX/MEM forwarding source
- memwb_reg_write, memwb_rd, memwb_data  in  1/REG_AW/DATA_W  MEM/WB forwarding source
- stall  out  1  freeze PC and IF/ID (combinational)
- ex_valid  out  1  EX holds a real instruction
- alu_op  out  3  to ALU `op`
- alu_in1, alu_in2  out  DATA_W  to ALU `in1`/`in2` (forwarded, combinational)
- ex_rd, ex_reg_write, ex_is_load  out  REG_AW/1/1  passed on to EX/MEM
- stall_cnt  out  16  load-use stall cycles, saturating

## Operation
- The stage holds these registered fields: valid, op, rs, rt, rd, rs_val, rt_val, imm, use_imm, is_load, reg_write.
- Hazard rule, combinational:
  - stall = !flush & id_valid & ex_valid & ex_is_load & ex_rd!=0 & (id_rs==ex_rd | (!id_use_imm & id_rt==ex_rd)).
- Register update on every clock edge, first matching case wins:
  - flush: load a bubble.
  - stall: load a bubble.
  - otherwise: load all id_* fields, with valid=id_valid.
- A bubble is valid=0, reg_write=0, is_load=0 and op=0. The other fields are don't-care but must be cleared to 0.
- Forwarding, applied separately to rs and rt:
  - Use exmem_alu_out if exmem_reg_write & exmem_rd!=0 & exmem_rd==reg.
  - Else use memwb_data if memwb_reg_write & memwb_rd!=0 & memwb_rd==reg.
  - Else use the registered value.
  - EX/MEM has priority over MEM/WB.
- alu_in1 = forwarded rs.
- alu_in2 = imm when use_imm is set; otherwise forwarded rt.
- stall_cnt increments by 1 on each clock edge where stall=1, and holds at 16'hFFFF.

## Timing
- Latency is 1 cycle: ID fields sampled at edge N appear on the alu_* outputs after edge N.
- Forwarding is same-cycle combinational; no extra latency.
- A load-use hazard costs exactly one stall cycle. The bubble-loaded EX then clears ex_is_load, which drops stall. The dependent instruction is then forwarded from MEM/WB.
- Flush and stall in the same cycle: flush wins, stall=0, a bubble is loaded, and stall_cnt does not increment.
- Reset values, asserted asynchronously mid-cycle and held until release:
  - ex_valid=0, alu_op=0, ex_rd=0, ex_reg_write=0, ex_is_load=0, stall_cnt=0.
  - alu_in1=alu_in2=0, because no forwarding source matches register 0.
  - stall=0.
- The first edge after reset deassertion samples ID normally.
- A register-0 destination never forwards and never triggers a stall.
- id_valid=0 with no flush and no stall loads a bubble.

## Test plan
- **Basic pass-through:** id_op=1, rs_val=5, rt_val=7, no hazards. Required after one edge: ex_valid=1, alu_op=1, alu_in1=5, alu_in2=7.
- **Dual-source forwarding:** EX holds rs=3, rt=4. Drive exmem_rd=3 with exmem_alu_out=0xAAAA, and memwb_rd=3 and memwb_rd=4 with memwb_data=0x5555. Required: alu_in1=0xAAAA, alu_in2=0x5555. With both sources targeting r0: registered values pass through.
- **Load-use:** EX holds a load with rd=8; ID reads rs=8. Required:
  - stall=1 for one cycle, then a bubble in EX (ex_valid=0), then stall=0.
  - stall_cnt=1.
  - Next issue with memwb_rd=8, memwb_data=0x1234 gives alu_in1=0x1234.
- **Immediate masks the hazard:** EX holds a load with rd=8; ID has id_rt=8 and id_use_imm=1, rs≠8. Required: stall=0 and alu_in2=imm.
- **Flush with simultaneous load-use:** flush=1 during a load-use condition. Required: stall=0, a bubble loads, stall_cnt unchanged.
- **Async reset and saturation:**
  - Assert reset between edges with a valid instruction in EX. Required: outputs zero immediately, without waiting for a clock edge.
  - Preset stall_cnt to 0xFFFE and hold a hazard for 3 cycles. Required: stall_cnt reads 0xFFFF.
